// File: rtl/wm_pkg.sv
// Shared washing-machine controller definitions: state encodings and default
// phase durations used by the controller FSM and phase_timer.
package wm_pkg;

    typedef enum logic [2:0] {
        STATE_IDLE       = 3'd0,
        STATE_START      = 3'd1,
        STATE_FILL_WATER = 3'd2,
        STATE_HEAT_WATER = 3'd3,
        STATE_WASH       = 3'd4,
        STATE_RINSE      = 3'd5,
        STATE_SPIN       = 3'd6,
        STATE_DONE       = 3'd7
    } wm_state_e;

    localparam int unsigned FILL_TIME_DEF  = 2;
    localparam int unsigned HEAT_TIME_DEF  = 3;
    localparam int unsigned WASH_TIME_DEF  = 5;
    localparam int unsigned RINSE_TIME_DEF = 3;
    localparam int unsigned SPIN_TIME_DEF  = 3;

    function automatic logic is_timed(input logic [2:0] s);
        return (s >= 3'(STATE_FILL_WATER)) && (s <= 3'(STATE_SPIN));
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Generic saturating up-counter with clear, load-one and enable; it never
// counts past the terminal value supplied on term_i.
module phase_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             load_one_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_one_i) begin
            count_d = CNT_W'(1);
        end else if (enable_i && (count_q < term_i)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/phase_timer.sv
// Per-phase elapsed-cycle timer raising a level done flag per timed phase.
// Define PHASE_TIMER_REMAINING_EN to add the 'remaining' cycles output.
module phase_timer
    import wm_pkg::*;
#(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned FILL_TIME  = FILL_TIME_DEF,
    parameter int unsigned HEAT_TIME  = HEAT_TIME_DEF,
    parameter int unsigned WASH_TIME  = WASH_TIME_DEF,
    parameter int unsigned RINSE_TIME = RINSE_TIME_DEF,
    parameter int unsigned SPIN_TIME  = SPIN_TIME_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       state,
    input  logic             pause,
    output logic             sig_Full,
    output logic             sig_Temperature,
    output logic             sig_Wash_Done,
    output logic             sig_Rinse_Done,
    output logic             sig_Completed
`ifdef PHASE_TIMER_REMAINING_EN
    ,
    output logic [CNT_W-1:0] remaining
`endif
);

    localparam int unsigned MAX_DUR = (1 << CNT_W) - 1;

    if (FILL_TIME < 1 || FILL_TIME > MAX_DUR || HEAT_TIME < 1 || HEAT_TIME > MAX_DUR ||
        WASH_TIME < 1 || WASH_TIME > MAX_DUR || RINSE_TIME < 1 || RINSE_TIME > MAX_DUR ||
        SPIN_TIME < 1 || SPIN_TIME > MAX_DUR) begin : g_bad_duration
        $error("phase_timer: every phase duration must lie in 1 .. 2**CNT_W-1");
    end

    function automatic logic [CNT_W-1:0] dur_of(input logic [2:0] s);
        logic [CNT_W-1:0] d;
        d = '0;
        case (s)
            3'(STATE_FILL_WATER): d = CNT_W'(FILL_TIME);
            3'(STATE_HEAT_WATER): d = CNT_W'(HEAT_TIME);
            3'(STATE_WASH):       d = CNT_W'(WASH_TIME);
            3'(STATE_RINSE):      d = CNT_W'(RINSE_TIME);
            3'(STATE_SPIN):       d = CNT_W'(SPIN_TIME);
            default:              d = '0;
        endcase
        return d;
    endfunction

    logic [2:0]       prev_state_q;
    logic [CNT_W-1:0] elapsed;
    logic [CNT_W-1:0] dur_prev;
    logic             entry;
    logic             timed;
    logic             cnt_clear;
    logic             cnt_load_one;
    logic             cnt_enable;
    logic             at_dur;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_state_q <= 3'(STATE_IDLE);
        end else begin
            prev_state_q <= state;
        end
    end

    // On non-entry edges state == prev_state, so DUR(prev_state) serves as
    // both the saturation limit and the done compare value.
    assign entry        = (state != prev_state_q);
    assign timed        = is_timed(state);
    assign dur_prev     = dur_of(prev_state_q);
    assign cnt_clear    = !timed || (entry && pause);
    assign cnt_load_one = timed && entry && !pause;
    assign cnt_enable   = timed && !entry && !pause;

    phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_i    (cnt_clear),
        .load_one_i (cnt_load_one),
        .enable_i   (cnt_enable),
        .term_i     (dur_prev),
        .count_o    (elapsed)
    );

    assign at_dur = (elapsed == dur_prev);

    always_comb begin
        sig_Full        = 1'b0;
        sig_Temperature = 1'b0;
        sig_Wash_Done   = 1'b0;
        sig_Rinse_Done  = 1'b0;
        sig_Completed   = 1'b0;
        case (prev_state_q)
            3'(STATE_FILL_WATER): sig_Full        = at_dur;
            3'(STATE_HEAT_WATER): sig_Temperature = at_dur;
            3'(STATE_WASH):       sig_Wash_Done   = at_dur;
            3'(STATE_RINSE):      sig_Rinse_Done  = at_dur;
            3'(STATE_SPIN):       sig_Completed   = at_dur;
            default: ;
        endcase
    end

`ifdef PHASE_TIMER_REMAINING_EN
    assign remaining = is_timed(prev_state_q) ? (dur_prev - elapsed) : '0;
`endif

endmodule
